// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Scoreboard hazard unit for the in-order pipeline. It tracks a
//            latency countdown per architectural register, detects RAW and
//            WAW conflicts for the instruction in ID, stalls IF/ID, injects an
//            EX bubble, and counts stall cycles.
// Ports    : clk, rst_n (async, active-low)
//            id_valid/id_rs/id_rs_used/id_rd/id_rd_we/id_lat : ID instruction
//            flush_i   : ID instruction is wrong-path
//            sb_clear  : drop all pending entries
//            wb_valid/wb_rd : writeback of an unknown-latency result
//            stall_if/stall_id/flush_ex : hazard response (all identical)
//            hazard_rs : per-source RAW flag
//            busy_vec  : pending-register vector
//            stall_cnt : saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_RS = 2,
    parameter int LAT_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NUM_RS-1:0][4:0] id_rs,
    input  logic [NUM_RS-1:0]      id_rs_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_rd_we,
    input  logic [LAT_W-1:0]       id_lat,
    input  logic                   flush_i,
    input  logic                   sb_clear,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   flush_ex,
    output logic [NUM_RS-1:0]      hazard_rs,
    output logic [31:0]            busy_vec,
    output logic [CNT_W-1:0]       stall_cnt
);

    // All-ones latency marks an entry that only writeback can release.
    localparam logic [LAT_W-1:0] LAT_UNK = '1;
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic w_waw;
    logic w_stall;
    logic w_issue;

    // ------------------------------------------------------------------------
    // Hazard detection, purely from registered busy state
    // ------------------------------------------------------------------------
    genvar i;
    generate
        for (i = 0; i < NUM_RS; i++) begin : g_rs
            assign hazard_rs[i] = id_valid & id_rs_used[i] &
                                  (id_rs[i] != 5'd0) & busy_vec[id_rs[i]];
        end
    endgenerate

    assign w_waw    = id_valid & id_rd_we & (id_rd != 5'd0) & busy_vec[id_rd];
    assign w_stall  = ((|hazard_rs) | w_waw) & ~flush_i;
    assign w_issue  = id_valid & ~w_stall & ~flush_i & ~sb_clear;

    assign stall_if = w_stall;
    assign stall_id = w_stall;
    assign flush_ex = w_stall;

    // x0 has no storage and is never pending.
    assign busy_vec[0] = 1'b0;

    // ------------------------------------------------------------------------
    // Per-register latency countdown for x1..x31
    // ------------------------------------------------------------------------
    genvar r;
    generate
        for (r = 1; r < 32; r++) begin : g_reg
            localparam logic [4:0] c_addr = 5'(r);

            logic [LAT_W-1:0] r_cnt;
            logic             w_set;
            logic             w_wb;

            assign w_set = w_issue & id_rd_we & (id_rd == c_addr);
            assign w_wb  = wb_valid & (wb_rd == c_addr);

            // Priority: clear, new issue, writeback, countdown.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (sb_clear) begin
                    r_cnt <= '0;
                end else if (w_set) begin
                    r_cnt <= id_lat;
                end else if (w_wb) begin
                    r_cnt <= '0;
                end else if ((r_cnt != '0) && (r_cnt != LAT_UNK)) begin
                    r_cnt <= r_cnt - LAT_ONE;
                end
            end

            assign busy_vec[r] = (r_cnt != '0);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stall-cycle counter; saturates and survives sb_clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (w_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard. A second
//            instance with a 2-bit stall counter shares all inputs to check
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam logic [3:0] LAT_UNK = 4'hF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [1:0][4:0] id_rs;
    logic [1:0]      id_rs_used;
    logic [4:0]      id_rd;
    logic            id_rd_we;
    logic [3:0]      id_lat;
    logic            flush_i;
    logic            sb_clear;
    logic            wb_valid;
    logic [4:0]      wb_rd;

    logic            stall_if, stall_id, flush_ex;
    logic [1:0]      hazard_rs;
    logic [31:0]     busy_vec;
    logic [15:0]     stall_cnt;

    logic            s_stall_if, s_stall_id, s_flush_ex;
    logic [1:0]      s_hazard_rs;
    logic [31:0]     s_busy_vec;
    logic [1:0]      s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_RS(2), .LAT_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_lat(id_lat), .flush_i(flush_i), .sb_clear(sb_clear),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_if(stall_if),
        .stall_id(stall_id), .flush_ex(flush_ex), .hazard_rs(hazard_rs),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.NUM_RS(2), .LAT_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_lat(id_lat), .flush_i(flush_i), .sb_clear(sb_clear),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_if(s_stall_if),
        .stall_id(s_stall_id), .flush_ex(s_flush_ex), .hazard_rs(s_hazard_rs),
        .busy_vec(s_busy_vec), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stall outputs packed as {stall_if, stall_id, flush_ex}
    task automatic chk_stall(input string tag, input logic exp);
        chk(tag, {29'd0, stall_if, stall_id, flush_ex}, exp ? 32'd7 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rs[0]   = 5'd0;
        id_rs[1]   = 5'd0;
        id_rs_used = 2'b00;
        id_rd      = 5'd0;
        id_rd_we   = 1'b0;
        id_lat     = 4'd0;
        flush_i    = 1'b0;
        sb_clear   = 1'b0;
        wb_valid   = 1'b0;
        wb_rd      = 5'd0;
    endtask

    task automatic instr(input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic we, input logic [3:0] lat);
        id_valid   = 1'b1;
        id_rs[0]   = rs0;
        id_rs[1]   = rs1;
        id_rs_used = used;
        id_rd      = rd;
        id_rd_we   = we;
        id_lat     = lat;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // ---------------- reset ----------------
        tick(); tick();
        chk_stall("rst_stall", 1'b0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_haz", {30'd0, hazard_rs}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk_stall("post_rst_stall", 1'b0);
        chk("post_rst_busy", busy_vec, 32'd0);

        // ---------------- load-use: lw x5 lat 1 ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 4'd1);
        #1 chk_stall("lu_producer", 1'b0);
        tick();
        instr(5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 4'd0);  // add x6,x5,x1
        #1 chk_stall("lu_stall", 1'b1);
        chk("lu_haz", {30'd0, hazard_rs}, 32'd1);
        chk("lu_busy", busy_vec, 32'h0000_0020);
        tick();
        #1 chk_stall("lu_issue", 1'b0);
        chk("lu_busy_clr", busy_vec, 32'd0);
        tick();
        idle();
        #1 chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        chk("lu_cnt_sat", {30'd0, s_stall_cnt}, 32'd1);

        // ---------------- mul chain: mul x7 lat 3 ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 4'd3);
        tick();
        instr(5'd7, 5'd2, 2'b01, 5'd8, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            #1 chk_stall($sformatf("mul_stall%0d", k), 1'b1);
            chk($sformatf("mul_haz%0d", k), {30'd0, hazard_rs}, 32'd1);
            chk($sformatf("mul_busy%0d", k), {31'd0, busy_vec[7]}, 32'd1);
            tick();
        end
        #1 chk_stall("mul_issue", 1'b0);
        chk("mul_busy_clr", {31'd0, busy_vec[7]}, 32'd0);
        tick();
        idle();
        #1 chk("mul_cnt", {16'd0, stall_cnt}, 32'd4);
        chk("mul_cnt_sat", {30'd0, s_stall_cnt}, 32'd3);

        // ---------------- unknown latency: div x9 ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, LAT_UNK);
        tick();
        instr(5'd3, 5'd9, 2'b10, 5'd10, 1'b1, 4'd0);
        for (int k = 0; k < 20; k++) begin
            #1 chk_stall($sformatf("div_hold%0d", k), 1'b1);
            tick();
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        #1 chk_stall("div_wb_cycle", 1'b1);
        chk("div_haz", {30'd0, hazard_rs}, 32'd2);
        tick();
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        #1 chk_stall("div_issue", 1'b0);
        chk("div_busy_clr", busy_vec, 32'd0);
        tick();
        idle();
        #1 chk("div_cnt", {16'd0, stall_cnt}, 32'd25);
        chk("div_cnt_sat", {30'd0, s_stall_cnt}, 32'd3);

        // ---------------- x0 and unused operands ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 4'd3);   // write x0, lat 3
        tick();
        instr(5'd0, 5'd0, 2'b11, 5'd11, 1'b0, 4'd0);  // reads x0
        #1 chk("x0_busy", busy_vec, 32'd0);
        chk_stall("x0_stall", 1'b0);
        tick();
        instr(5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 4'd5);   // x3 pending lat 5
        tick();
        instr(5'd3, 5'd3, 2'b00, 5'd12, 1'b0, 4'd0);  // names x3, unused
        #1 chk("unused_busy", busy_vec, 32'h0000_0008);
        chk_stall("unused_stall", 1'b0);
        chk("unused_haz", {30'd0, hazard_rs}, 32'd0);
        tick();
        idle();
        repeat (4) tick();
        chk("x3_drain", busy_vec, 32'd0);

        // ---------------- WAW and issue-vs-writeback priority ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 4'd1);   // lw x4
        tick();
        instr(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, LAT_UNK); // div x4
        #1 chk_stall("waw_stall", 1'b1);
        chk("waw_haz", {30'd0, hazard_rs}, 32'd0);
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        #1 chk_stall("waw_issue", 1'b0);
        tick();
        idle();
        #1 chk("waw_wb_lose", busy_vec, 32'h0000_0010);
        repeat (3) tick();
        chk("waw_unk_hold", busy_vec, 32'h0000_0010);
        chk("waw_cnt", {16'd0, stall_cnt}, 32'd26);

        // ---------------- flush_i during hazard ----------------
        instr(5'd4, 5'd0, 2'b01, 5'd11, 1'b1, 4'd3);
        flush_i = 1'b1;
        #1 chk_stall("flush_stall", 1'b0);
        chk("flush_haz", {30'd0, hazard_rs}, 32'd1);
        tick();
        idle();
        #1 chk("flush_no_entry", busy_vec, 32'h0000_0010);
        chk("flush_cnt", {16'd0, stall_cnt}, 32'd26);

        // ---------------- sb_clear with 3 busy registers ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 4'd7);
        tick();
        instr(5'd0, 5'd0, 2'b00, 5'd13, 1'b1, LAT_UNK);
        tick();
        instr(5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 4'd2);
        sb_clear = 1'b1;
        #1 chk("clr_before", busy_vec, 32'h0000_3010);
        tick();
        idle();
        #1 chk("clr_after", busy_vec, 32'd0);
        chk("clr_keeps_cnt", {16'd0, stall_cnt}, 32'd26);

        // ---------------- reset mid-stall ----------------
        instr(5'd0, 5'd0, 2'b00, 5'd20, 1'b1, 4'd9);
        tick();
        instr(5'd20, 5'd0, 2'b01, 5'd21, 1'b1, 4'd0);
        #1 chk_stall("mid_stall", 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_stall("mid_rst_stall", 1'b0);
        chk("mid_rst_busy", busy_vec, 32'd0);
        chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_rst_cnt_sat", {30'd0, s_stall_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
